// File: rtl/vector_lsu_sequencer.sv
//------------------------------------------------------------------------------
// Module      : vector_lsu_sequencer
// Description : Unit-stride SEW=8 vector load/store sequencer. It issues one
//               OBI word transaction per vector register, one at a time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vector_lsu_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int VL_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [4:0]            vreg_addr,
    input  logic [VL_WIDTH-1:0]   vl,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  data_req,
    input  logic                  data_gnt,
    input  logic                  data_rvalid,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_we,
    output logic [3:0]            data_be,
    output logic [31:0]           data_wdata,
    input  logic [31:0]           data_rdata,
    output logic [4:0]            vr_rd_addr,
    input  logic [31:0]           vr_rd_data,
    output logic                  vr_wr_en,
    output logic [4:0]            vr_wr_addr,
    output logic [31:0]           vr_wr_data,
    output logic [3:0]            vr_wr_be
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_idx;
    logic                  r_is_store;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [4:0]            r_vreg;
    logic [VL_WIDTH-1:0]   r_vl;

    logic [2:0]            w_last;
    logic                  w_is_last;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [4:0]            w_vreg;
    logic                  w_misaligned;
    logic                  w_vl_zero;

    // Index of the final word; only meaningful once vl is known to be nonzero.
    assign w_last       = r_vl[4:2] - {2'b00, ~|r_vl[1:0]};
    assign w_is_last    = (r_idx == w_last);
    assign w_be         = (w_is_last && (|r_vl[1:0])) ? ((4'd1 << r_vl[1:0]) - 4'd1) : 4'hF;
    assign w_addr       = r_base + ADDR_WIDTH'({r_idx, 2'b00});
    assign w_vreg       = r_vreg + {2'b00, r_idx};
    assign w_misaligned = |base_addr[1:0];
    assign w_vl_zero    = (vl == '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_is_store <= 1'b0;
            r_error    <= 1'b0;
            r_base     <= '0;
            r_vreg     <= 5'd0;
            r_vl       <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && start) begin
                r_idx      <= 3'd0;
                r_is_store <= is_store;
                r_error    <= w_misaligned;
                r_base     <= base_addr;
                r_vreg     <= vreg_addr;
                r_vl       <= vl;
            end else if (r_state == S_RESP && data_rvalid && !w_is_last) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        data_req     = 1'b0;
        data_addr    = '0;
        data_we      = 1'b0;
        data_be      = 4'h0;
        data_wdata   = 32'h0;
        vr_rd_addr   = 5'd0;
        vr_wr_en     = 1'b0;
        vr_wr_addr   = 5'd0;
        vr_wr_data   = 32'h0;
        vr_wr_be     = 4'h0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (w_misaligned || w_vl_zero) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                data_req  = 1'b1;
                data_we   = r_is_store;
                data_addr = w_addr;
                data_be   = w_be;
                if (r_is_store) begin
                    vr_rd_addr = w_vreg;
                    data_wdata = vr_rd_data;
                end
                if (data_gnt) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (data_rvalid) begin
                    // Load data goes straight into the register file in the rvalid cycle.
                    if (!r_is_store) begin
                        vr_wr_en   = 1'b1;
                        vr_wr_addr = w_vreg;
                        vr_wr_data = data_rdata;
                        vr_wr_be   = w_be;
                    end
                    w_state_next = w_is_last ? S_FIN : S_REQ;
                end
            end
            S_FIN: begin
                done         = 1'b1;
                error        = r_error;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
